// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-way fetch/data arbiter onto one single-port memory
// Data side wins by default; a starvation counter forces a waiting fetch through after MAX_DWELL data grants.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_valid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_valid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_DWELL + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DATA,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic               w_starved;
    logic               w_pick_data;

    assign w_starved   = (r_starve_cnt >= CNT_W'(MAX_DWELL));
    assign w_pick_data = d_req & (~w_starved | ~if_req);

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            if_valid     <= 1'b0;
            d_valid      <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A fetch that is not waiting has nothing to be starved of.
                    if (!if_req) begin
                        r_starve_cnt <= '0;
                    end
                    if (w_pick_data) begin
                        r_state   <= S_DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_we ? d_wstrb : STRB_W'(0);
                        if (if_req && !w_starved) begin
                            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                        end
                    end else if (if_req) begin
                        r_state      <= S_FETCH;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr;
                        mem_wdata    <= '0;
                        mem_wstrb    <= '0;
                        r_starve_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        if_rdata <= mem_rdata;
                        if_valid <= 1'b1;
                        mem_req  <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DATA: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        d_valid <= 1'b1;
                        mem_req <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_wstrb;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_if;
    logic          stall_mem;

    logic          dir_ack;
    logic [DW-1:0] dir_rdata;
    logic          rsp_ack;
    logic [DW-1:0] rsp_rdata;
    logic          auto_ack;
    logic          rnd_on;

    assign mem_ack   = dir_ack | rsp_ack;
    assign mem_rdata = rsp_ack ? rsp_rdata : dir_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_DWELL (MAXD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // Directed memory side: waits for mem_req, acks after lat cycles, returns in the valid cycle.
    task automatic serve(input logic [31:0] rd, input int lat,
                         output logic [31:0] s_addr, output logic s_we,
                         output logic [3:0] s_wstrb, output logic [31:0] s_wdata);
        int t;
        t = 0;
        while (mem_req !== 1'b1 && t < 20) begin
            tick;
            t++;
        end
        check_val("serve_req_seen", mem_req, 1);
        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wstrb = mem_wstrb;
        s_wdata = mem_wdata;
        repeat (lat) tick;
        dir_ack   = 1'b1;
        dir_rdata = rd;
        tick;
        dir_ack   = 1'b0;
    endtask

    // Randomized-phase memory responder with byte-strobed writes into the model memory.
    initial begin
        rsp_ack   = 1'b0;
        rsp_rdata = '0;
        forever begin
            @(negedge clk);
            if (auto_ack && mem_req === 1'b1 && !mem_ack) begin
                logic [31:0] a;
                logic [31:0] wd;
                logic [31:0] v;
                logic [3:0]  st;
                logic        we;
                a  = mem_addr;
                wd = mem_wdata;
                st = mem_wstrb;
                we = mem_we;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                rsp_rdata = mem_rd(a);
                rsp_ack   = 1'b1;
                if (we) begin
                    v = mem_rd(a);
                    for (int b = 0; b < 4; b++) begin
                        if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
                    end
                    mem_model[a] = v;
                end
                @(posedge clk);
                #1;
                rsp_ack = 1'b0;
            end
        end
    end

    // Reference scoreboard: grant choice from the priority/starvation rule, data from the model memory.
    logic          p_if_req, p_d_req, p_d_we, p_mem_req;
    logic [31:0]   p_if_addr, p_d_addr, p_d_wdata;
    logic [3:0]    p_d_wstrb;
    int            m_cnt;
    logic          own_d;
    logic          own_we;
    logic          valid_due;
    logic [31:0]   exp_ifrd, exp_drd;

    initial begin
        p_mem_req = 1'b0;
        valid_due = 1'b0;
        forever begin
            @(negedge clk);
            if (rnd_on) begin
                check_val("stall_if", stall_if, if_req & ~if_valid);
                check_val("stall_mem", stall_mem, d_req & ~d_valid);
                if (valid_due) begin
                    valid_due = 1'b0;
                    if (own_d) begin
                        check_val("rnd_d_valid", {if_valid, d_valid}, 2'b01);
                        check_val("rnd_d_rdata", d_rdata, exp_drd);
                    end else begin
                        check_val("rnd_if_valid", {if_valid, d_valid}, 2'b10);
                        check_val("rnd_if_rdata", if_rdata, exp_ifrd);
                    end
                end else begin
                    check_val("rnd_no_valid", {if_valid, d_valid}, 2'b00);
                end
                if (mem_req && !p_mem_req) begin
                    logic want_d;
                    want_d = p_d_req && (m_cnt < MAXD || !p_if_req);
                    check_val("grant_has_req", p_if_req | p_d_req, 1);
                    check_val("grant_addr", mem_addr, want_d ? p_d_addr : p_if_addr);
                    check_val("grant_we", mem_we, want_d & p_d_we);
                    check_val("grant_wstrb", mem_wstrb, (want_d && p_d_we) ? p_d_wstrb : 4'h0);
                    if (want_d && p_d_we) check_val("grant_wdata", mem_wdata, p_d_wdata);
                    if (!p_if_req || !want_d) m_cnt = 0;
                    else if (m_cnt < MAXD) m_cnt++;
                    own_d  = want_d;
                    own_we = want_d & p_d_we;
                    if (!want_d) exp_ifrd = mem_rd(p_if_addr);
                    else if (!p_d_we) exp_drd = mem_rd(p_d_addr);
                end
                if (mem_req && mem_ack) valid_due = 1'b1;
            end
            p_if_req  = if_req;
            p_if_addr = if_addr;
            p_d_req   = d_req;
            p_d_we    = d_we;
            p_d_addr  = d_addr;
            p_d_wdata = d_wdata;
            p_d_wstrb = d_wstrb;
            p_mem_req = mem_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd;
        logic        we;
        logic [3:0]  st;
        logic [5:0]  order;
        logic [31:0] last_drd;

        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_wstrb = 0; dir_ack = 0; dir_rdata = 0; auto_ack = 0; rnd_on = 0;
        m_cnt = 0; exp_drd = 0; exp_ifrd = 0; own_d = 0; own_we = 0;
        tick;
        tick;
        check_val("rst_mem", {mem_req, mem_we, mem_wstrb}, 0);
        check_val("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 0);
        check_val("rst_valids", {if_valid, d_valid}, 0);
        check_val("rst_rdata", {if_rdata, d_rdata}, 0);
        rst = 1'b0;
        tick;

        // Single fetch with ack two cycles after mem_req.
        if_req = 1; if_addr = 32'h100;
        serve(32'h0000_0013, 2, a, we, st, wd);
        check_val("t1_addr", a, 32'h100);
        check_val("t1_we_strb", {we, st}, 0);
        check_val("t1_valid", {if_valid, d_valid, mem_req}, 3'b100);
        check_val("t1_rdata", if_rdata, 32'h13);
        check_val("t1_stall_if", stall_if, 0);
        if_req = 0;
        tick;
        check_val("t1_pulse_end", if_valid, 0);
        check_val("t1_hold", if_rdata, 32'h13);

        // Simultaneous fetch and load: data first.
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 0; d_addr = 32'h2000;
        serve(32'h1234_5678, 1, a, we, st, wd);
        check_val("t2_data_first", a, 32'h2000);
        check_val("t2_d_valid", {if_valid, d_valid}, 2'b01);
        check_val("t2_d_rdata", d_rdata, 32'h1234_5678);
        check_val("t2_stall_if", {stall_if, stall_mem}, 2'b10);
        d_req = 0;
        serve(32'h0000_0093, 1, a, we, st, wd);
        check_val("t2_fetch_next", a, 32'h200);
        check_val("t2_if_valid", {if_valid, d_valid}, 2'b10);
        check_val("t2_if_rdata", if_rdata, 32'h93);
        if_req = 0;
        tick;

        // Continuous data pressure: fetch gets in after MAX_DWELL data grants.
        if_req = 1; if_addr = 32'h204;
        d_req = 1; d_we = 0; d_addr = 32'h2004;
        order = '0;
        for (int g = 0; g < 6; g++) begin
            serve(32'(g), 1, a, we, st, wd);
            order[g] = (a == 32'h204);
            if (a == 32'h204) if_req = 0;
        end
        check_val("t3_order", order, 6'b010000);
        check_val("t3_last_load", d_rdata, 32'd5);
        last_drd = 32'd5;
        d_req = 0;
        if_req = 0;
        tick;

        // Store: strobes forwarded, d_rdata untouched.
        d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        serve(32'h5555_5555, 1, a, we, st, wd);
        check_val("t4_addr", a, 32'h3000);
        check_val("t4_we_strb", {we, st}, 5'b1_0011);
        check_val("t4_wdata", wd, 32'hDEAD_BEEF);
        check_val("t4_d_valid", d_valid, 1);
        check_val("t4_d_rdata", d_rdata, last_drd);
        d_req = 0; d_we = 0; d_wstrb = 0;
        tick;

        // Reset in the middle of a load; late ack must be ignored.
        d_req = 1; d_addr = 32'h2008;
        tick;
        check_val("t5_req_up", mem_req, 1);
        rst = 1; d_req = 0;
        tick;
        check_val("t5_rst_req", {mem_req, d_valid}, 0);
        rst = 0; dir_ack = 1; dir_rdata = 32'h0000_0BAD;
        tick;
        dir_ack = 0;
        check_val("t5_late_ack", {mem_req, d_valid, if_valid}, 0);
        check_val("t5_d_rdata", d_rdata, 0);
        tick;
        check_val("t5_idle", {mem_req, d_valid}, 0);

        // Spurious ack in IDLE.
        dir_ack = 1; dir_rdata = 32'hFFFF_FFFF;
        tick;
        dir_ack = 0;
        check_val("t6_no_valid", {if_valid, d_valid, mem_req}, 0);
        tick;
        check_val("t6_still_idle", {if_valid, d_valid, mem_req}, 0);
        check_val("t6_rdata_kept", {if_rdata, d_rdata}, 0);

        // Randomized traffic against the scoreboard.
        rst = 1;
        tick;
        rst = 0;
        m_cnt = 0; exp_drd = 0; valid_due = 0;
        auto_ack = 1;
        rnd_on = 1;
        fork
            begin : gen_fetch
                int w;
                for (int n = 0; n < 50; n++) begin
                    repeat ($urandom_range(0, 4)) tick;
                    if_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
                    if_req  = 1;
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!if_valid && w < 300);
                    if (!if_valid) begin
                        check_val("fetch_timeout", 0, 1);
                        if_req = 0;
                        break;
                    end
                    tick;
                    if_req = 0;
                end
            end
            begin : gen_data
                int w;
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(0, 3)) tick;
                    d_addr  = 32'h100 + 32'(4 * $urandom_range(0, 7));
                    d_we    = 1'($urandom_range(0, 1));
                    d_wdata = $urandom;
                    d_wstrb = 4'($urandom_range(0, 15));
                    d_req   = 1;
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!d_valid && w < 300);
                    if (!d_valid) begin
                        check_val("data_timeout", 0, 1);
                        d_req = 0;
                        break;
                    end
                    tick;
                    d_req = 0;
                    d_we  = 0;
                end
            end
        join
        repeat (6) tick;
        rnd_on = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
